// File: rtl/seg7_pkg.sv
// Shared 7-segment constants for the mod-12 counter display path.
// All segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam int   CNT12_MAX = 11;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10..15 are not decimal digits and render as a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  // Table lookup for 0..9, dash for anything else.
  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/cnt12_disp.sv
// Two-digit multiplexed display for a mod-12 counter value.
// A prescaler sets the per-digit slot length, sel scans units then tens,
// and q_in is latched only at frame start so both digits of a frame come
// from the same counter value.
// Optional build macro: CNT12_DISP_LEAD_BLANK_EN blanks a leading-zero tens
// digit (anode scan is unchanged so brightness stays uniform).
module cnt12_disp
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp,
  output logic       err
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] pcnt;
  logic          tick;
  logic          sel;
  logic [3:0]    q_lat;
  logic          in_range;
  logic          tens;
  logic [3:0]    units;
  logic [3:0]    digit;
  seg_t          dseg;
  seg_t          seg_nxt;

  assign tick = (pcnt == PW'(REFRESH_DIV - 1));

  // Prescaler: one tick per digit slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  // Scan select and frame-aligned latch; q_in is sampled only when the
  // tens slot ends (sel 1->0), which is the start of the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel   <= 1'b0;
      q_lat <= 4'd0;
    end else if (tick) begin
      sel <= ~sel;
      if (sel) q_lat <= q_in;
    end
  end

  // Digit split: 10 and 11 are the only two-digit values.
  assign in_range = (q_lat <= 4'(CNT12_MAX));
  assign tens     = (q_lat >= 4'd10);
  assign units    = tens ? (q_lat - 4'd10) : q_lat;

  // Pick the digit for the active slot; out-of-range forces a dash code.
  always_comb begin
    digit = sel ? {3'b000, tens} : units;
    if (!in_range) digit = 4'hF;
  end

  seg7_decode u_dec (
    .bcd (digit),
    .seg (dseg)
  );

  // Final segment pattern, with optional leading-zero blanking.
  always_comb begin
    seg_nxt = dseg;
`ifdef CNT12_DISP_LEAD_BLANK_EN
    if (sel && !tens && in_range) seg_nxt = SEG_BLANK;
`else
    seg_nxt = dseg;
`endif
  end

  // Registered outputs, one cycle behind sel/q_lat; dark during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= 2'b11;
      err <= 1'b0;
    end else begin
      seg <= seg_nxt;
      an  <= sel ? 2'b01 : 2'b10;
      err <= ~in_range;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_cnt12_disp.sv
// Scoreboard bench for cnt12_disp with REFRESH_DIV = 4.
// The reference model derives each cycle's display from the edge count
// since reset release and the history of q_in values seen on each edge.
module tb_cnt12_disp;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] q_in = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;
  logic       err;

  typedef struct {
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   active = 0;
  int   t = 0;
  int   qhist [0:8191];
  int   cur = 0;

  cnt12_disp #(.REFRESH_DIV(D)) dut (
    .clk   (clk),
    .reset (reset),
    .q_in  (q_in),
    .seg   (seg),
    .an    (an),
    .dp    (dp),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dcode(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Display state after n clock edges since reset release.
  function automatic exp_t model(int n);
    exp_t e;
    int slot, frame, v;
    slot  = (n / D) % 2;
    frame = n / (2 * D);
    v     = (frame == 0) ? 0 : qhist[frame * 2 * D];
    e.an  = (slot == 1) ? 2'b01 : 2'b10;
    e.err = (v > 11);
    if (v > 11)          e.seg = 7'b0111111;
    else if (slot == 0)  e.seg = dcode(v % 10);
    else begin
      e.seg = dcode(v / 10);
`ifdef CNT12_DISP_LEAD_BLANK_EN
      if (v / 10 == 0) e.seg = 7'h7F;
`endif
    end
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h edge=%0d time=%0t", name, act, exp, t, $time);
    end
  endtask

  // Present v on the next edge and queue the display expected after it.
  task automatic step(int v);
    q_in = 4'(v);
    @(posedge clk);
    t++;
    qhist[t] = v;
    sb.push_back(model(t - 1));
    #1;
  endtask

  task automatic hold(int v, int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    t = 0;
    active = 1;
  endtask

  // Monitor: compare every cycle's outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (active && sb.size() > 0) begin
        e = sb.pop_front();
        chk("seg", 32'(seg), 32'(e.seg));
        chk("an",  32'(an),  32'(e.an));
        chk("err", 32'(err), 32'(e.err));
        chk("dp",  32'(dp),  32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state held across clock edges.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an",  32'(an),  32'h3);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_dp",  32'(dp),  32'h1);
    release_reset();

    hold(0, 6 * D);                      // leading zero / blank, scan period
    hold(11, 6 * D);                     // "11"
    hold(7, 2 * D + D / 2);              // mid-units-slot change 7 -> 10
    hold(10, 4 * D);
    hold(13, 4 * D);                     // out of range -> dash, err
    hold(3, 4 * D);
    for (int k = 0; k < 26; k++) hold(k % 12, 2 * D + 1);          // up with wrap
    for (int k = 0; k < 26; k++) hold((12 - (k % 12)) % 12, 2 * D - 1); // down with wrap
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) cur = int'($urandom_range(0, 15));
      step(cur);
    end

    // Asynchronous reset in the middle of a tens slot.
    begin
      int guard = 0;
      while (!(((t / D) % 2 == 1) && (t % D == 1)) && guard < 100) begin
        step(int'($urandom_range(0, 11)));
        guard++;
      end
      chk("tens_slot_reached", 32'(guard < 100), 32'd1);
    end
    @(negedge clk);
    #1;
    active = 0;
    sb.delete();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_an",  32'(an),  32'h3);
    chk("async_rst_err", 32'(err), 32'h0);
    repeat (2) @(posedge clk);
    release_reset();
    hold(5, 3 * D);
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) cur = int'($urandom_range(0, 15));
      step(cur);
    end

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
